// File: rtl/d_flip_flop_pkg.sv
// Shared types and constants for the d_flip_flop register slice.
// Optional clock enable across the slice: D_FLIP_FLOP_CLOCK_ENABLE_EN.
package d_flip_flop_pkg;

   typedef logic dff_bit_t;

   localparam int       DFF_DEFAULT_WIDTH = 1;
   localparam dff_bit_t DFF_RESET_ZERO    = 1'b0;

endpackage : d_flip_flop_pkg

// File: rtl/d_flip_flop_if.sv
// Data bundle for a d_flip_flop storage slice; the master drives data, the slave returns Q.
// The ce signal exists only when D_FLIP_FLOP_CLOCK_ENABLE_EN is defined.
interface d_flip_flop_if
   import d_flip_flop_pkg::*;
#(
   parameter int WIDTH = DFF_DEFAULT_WIDTH
);

   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
   logic             ce;
`endif

   modport master (
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
      output ce,
`endif
      output d,
      input  q
   );

   modport slave (
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
      input  ce,
`endif
      input  d,
      output q
   );

endinterface : d_flip_flop_if

// File: rtl/d_flip_flop_cell.sv
// One-bit D flop with synchronous active-low reset to RESET_VAL.
// With D_FLIP_FLOP_CLOCK_ENABLE_EN defined, ce gates the load and reset overrides ce.
module d_flip_flop_cell
   import d_flip_flop_pkg::*;
#(
   parameter dff_bit_t RESET_VAL = DFF_RESET_ZERO
) (
   d_flip_flop_if.slave bus,
   input  logic         clk,
   input  logic         rst_n
);

   // The final branch is only reachable in simulation: an unknown reset
   // must corrupt the stored bit instead of silently loading D.
   always_ff @(posedge clk) begin
      if (rst_n == 1'b0) begin
         bus.q <= RESET_VAL;
      end else if (rst_n == 1'b1) begin
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
         if (bus.ce) begin
            bus.q <= bus.d;
         end
`else
         bus.q <= bus.d;
`endif
      end else begin
         bus.q <= 'x;
      end
   end

endmodule : d_flip_flop_cell

// File: rtl/d_flip_flop.sv
// WIDTH-bit D register built from independent 1-bit cells, with Q_BAR = ~Q.
// Optional CE input appended after RST_N when D_FLIP_FLOP_CLOCK_ENABLE_EN is defined.
module d_flip_flop
   import d_flip_flop_pkg::*;
#(
   parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DFF_RESET_ZERO}}
) (
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_BAR,
   input  logic             CLK,
   input  logic             RST_N
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
   ,
   input  logic             CE
`endif
);

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      d_flip_flop_if #(.WIDTH(1)) cell_bus ();

      assign cell_bus.d = D[g];
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
      assign cell_bus.ce = CE;
`endif
      assign Q[g] = cell_bus.q;

      d_flip_flop_cell #(
         .RESET_VAL (RESET_VAL[g])
      ) u_cell (
         .bus   (cell_bus),
         .clk   (CLK),
         .rst_n (RST_N)
      );
   end

   assign Q_BAR = ~Q;

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// Directed and randomized checks of d_flip_flop: reset, capture latency, mid-run reset,
// between-edge immunity, a 4-instance feedback ring and (when enabled) clock-enable behaviour.
module tb_d_flip_flop;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // 4-bit instance, RESET_VAL = 1010
   d_flip_flop_if #(.WIDTH(4)) bus4 ();
   logic [3:0] qbar4;
   logic       rst_n4;

   d_flip_flop #(
      .WIDTH     (4),
      .RESET_VAL (4'b1010)
   ) dut4 (
      .D     (bus4.d),
      .Q     (bus4.q),
      .Q_BAR (qbar4),
      .CLK   (clk),
      .RST_N (rst_n4)
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
      ,
      .CE    (bus4.ce)
`endif
   );

   // 1-bit instance, default RESET_VAL = 0
   d_flip_flop_if #(.WIDTH(1)) bus1 ();
   logic qbar1;
   logic rst_n1;

   d_flip_flop #(
      .WIDTH (1)
   ) dut1 (
      .D     (bus1.d),
      .Q     (bus1.q),
      .Q_BAR (qbar1),
      .CLK   (clk),
      .RST_N (rst_n1)
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
      ,
      .CE    (bus1.ce)
`endif
   );

   // Feedback ring of four 1-bit instances, reset seed Q3..Q0 = 0100
   logic [3:0] rq;
   logic [3:0] rqb;
   logic       rst_nr;

   d_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) ring3 (
      .D(rq[1] ^ rq[0]), .Q(rq[3]), .Q_BAR(rqb[3]), .CLK(clk), .RST_N(rst_nr)
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
      , .CE(1'b1)
`endif
   );
   d_flip_flop #(.WIDTH(1), .RESET_VAL(1'b1)) ring2 (
      .D(rq[3]), .Q(rq[2]), .Q_BAR(rqb[2]), .CLK(clk), .RST_N(rst_nr)
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
      , .CE(1'b1)
`endif
   );
   d_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) ring1 (
      .D(rq[2]), .Q(rq[1]), .Q_BAR(rqb[1]), .CLK(clk), .RST_N(rst_nr)
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
      , .CE(1'b1)
`endif
   );
   d_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) ring0 (
      .D(rq[1]), .Q(rq[0]), .Q_BAR(rqb[0]), .CLK(clk), .RST_N(rst_nr)
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
      , .CE(1'b1)
`endif
   );

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic edge_then_sample();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp4;
   logic [3:0] d4;
   logic       r4;
   logic       exp1;
   logic       prev_d1;
   logic [3:0] ring_seq [6] = '{4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011};
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
   logic       ce4;
`endif

   initial begin
      rst_n4 = 1'b1;
      rst_n1 = 1'b1;
      rst_nr = 1'b1;
      bus4.d = '0;
      bus1.d = '0;
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
      bus4.ce = 1'b1;
      bus1.ce = 1'b1;
`endif

      // Reset loads RESET_VAL, release loads D on the first edge
      @(negedge clk);
      rst_n4 = 1'b0;
      bus4.d = 4'b0101;
      edge_then_sample();
      check("reset_q", bus4.q, 4'b1010);
      check("reset_qbar", qbar4, 4'b0101);
      @(negedge clk);
      rst_n4 = 1'b1;
      edge_then_sample();
      check("release_q", bus4.q, 4'b0101);
      check("release_qbar", qbar4, 4'b1010);
      exp4 = 4'b0101;

      // Randomized load/reset with between-edge glitches on D and RST_N
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("fall_hold", bus4.q, exp4);
         d4 = 4'($urandom);
         r4 = ($urandom_range(0, 5) != 0);
         bus4.d = d4;
         rst_n4 = r4;
`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
         ce4 = ($urandom_range(0, 2) != 0);
         bus4.ce = ce4;
         exp4 = !r4 ? 4'b1010 : (ce4 ? d4 : exp4);
`else
         exp4 = r4 ? d4 : 4'b1010;
`endif
         edge_then_sample();
         check("rand_q", bus4.q, exp4);
         check("rand_qbar", qbar4, ~exp4);
         #1;
         bus4.d = ~d4;
         rst_n4 = ~r4;
         #1;
         check("glitch_q", bus4.q, exp4);
         check("glitch_qbar", qbar4, ~exp4);
      end
      @(negedge clk);
      rst_n4 = 1'b1;

      // 1-bit: reset, then toggling D appears one edge later
      rst_n1 = 1'b0;
      bus1.d = 1'b1;
      edge_then_sample();
      check("w1_reset", {3'b000, bus1.q}, 4'b0000);
      check("w1_reset_bar", {3'b000, qbar1}, 4'b0001);
      @(negedge clk);
      rst_n1 = 1'b1;
      prev_d1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         prev_d1 = ~prev_d1;
         bus1.d = prev_d1;
         edge_then_sample();
         check("w1_capture", {3'b000, bus1.q}, {3'b000, prev_d1});
         check("w1_capture_bar", {3'b000, qbar1}, {3'b000, ~prev_d1});
         #2 bus1.d = ~prev_d1;
         #1 bus1.d = prev_d1;
         check("w1_glitch", {3'b000, bus1.q}, {3'b000, prev_d1});
      end

      // Mid-run reset, synchronous release, and a between-edge reset pulse
      @(negedge clk);
      bus1.d = 1'b1;
      repeat (3) edge_then_sample();
      check("mid_load", {3'b000, bus1.q}, 4'b0001);
      @(negedge clk);
      rst_n1 = 1'b0;
      edge_then_sample();
      check("mid_reset", {3'b000, bus1.q}, 4'b0000);
      check("mid_reset_bar", {3'b000, qbar1}, 4'b0001);
      @(negedge clk);
      rst_n1 = 1'b1;
      edge_then_sample();
      check("mid_release", {3'b000, bus1.q}, 4'b0001);
      #2 rst_n1 = 1'b0;
      #3 rst_n1 = 1'b1;
      edge_then_sample();
      check("pulse_ignored", {3'b000, bus1.q}, 4'b0001);
      exp1 = 1'b1;
      check("pulse_ignored_bar", {3'b000, qbar1}, {3'b000, ~exp1});

      // Ring: seed by reset, then shift with no race-through
      @(negedge clk);
      rst_nr = 1'b0;
      edge_then_sample();
      check("ring_seed", rq, ring_seq[0]);
      @(negedge clk);
      rst_nr = 1'b1;
      for (int i = 1; i < 6; i++) begin
         edge_then_sample();
         check("ring_step", rq, ring_seq[i]);
         check("ring_step_bar", rqb, ~ring_seq[i]);
      end

`ifdef D_FLIP_FLOP_CLOCK_ENABLE_EN
      // Clock enable: hold with CE=0, reset overrides CE=0, load with CE=1
      @(negedge clk);
      rst_n4 = 1'b1;
      bus4.ce = 1'b1;
      bus4.d = 4'b0011;
      edge_then_sample();
      check("ce_load", bus4.q, 4'b0011);
      @(negedge clk);
      bus4.ce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus4.d = 4'($urandom) | 4'b0100;
         edge_then_sample();
         check("ce_hold", bus4.q, 4'b0011);
         check("ce_hold_bar", qbar4, 4'b1100);
      end
      @(negedge clk);
      rst_n4 = 1'b0;
      edge_then_sample();
      check("ce_reset", bus4.q, 4'b1010);
      @(negedge clk);
      rst_n4 = 1'b1;
      bus4.ce = 1'b1;
      bus4.d = 4'b1111;
      edge_then_sample();
      check("ce_reload", bus4.q, 4'b1111);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_d_flip_flop
